// File: rtl/bus_arbiter_if.sv
// Bus bundle between N hart-side masters, the arbiter and the shared system-bus port.
// ARBITER_LOCK_EN adds the per-master lock request.
interface bus_arbiter_if #(
    parameter int N_MASTERS = 2
);
    logic [N_MASTERS-1:0]            i_m_bus_en;
    logic [N_MASTERS-1:0]            i_m_wr_en;
    logic [N_MASTERS-1:0][31:0]      i_m_addr;
    logic [N_MASTERS-1:0][31:0]      i_m_wr_data;
    logic [N_MASTERS-1:0][3:0]       i_m_byte_en;
`ifdef ARBITER_LOCK_EN
    logic [N_MASTERS-1:0]            i_m_lock;
`endif
    logic [N_MASTERS-1:0]            o_m_ack;
    logic [31:0]                     o_m_rd_data;
    logic [N_MASTERS-1:0]            o_grant;

    logic                            o_bus_en;
    logic                            o_wr_en;
    logic [31:0]                     o_addr;
    logic [31:0]                     o_wr_data;
    logic [3:0]                      o_byte_en;
    logic                            i_ack;
    logic [31:0]                     i_rd_data;

    // Arbiter view: requests and slave response in, acks and shared port out.
    modport slave (
`ifdef ARBITER_LOCK_EN
        input  i_m_lock,
`endif
        input  i_m_bus_en, i_m_wr_en, i_m_addr, i_m_wr_data, i_m_byte_en,
        input  i_ack, i_rd_data,
        output o_m_ack, o_m_rd_data, o_grant,
        output o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
    );

    modport master (
`ifdef ARBITER_LOCK_EN
        output i_m_lock,
`endif
        output i_m_bus_en, i_m_wr_en, i_m_addr, i_m_wr_data, i_m_byte_en,
        output i_ack, i_rd_data,
        input  o_m_ack, o_m_rd_data, o_grant,
        input  o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one registered bus-master port among N_MASTERS harts.
// Optional ARBITER_LOCK_EN keeps a locked master's RMW sequence indivisible.
module bus_arbiter #(
    parameter int N_MASTERS = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    bus_arbiter_if.slave bus
);
    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          last_q, last_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic                   bus_en_q, bus_en_d;
    logic                   wr_en_q, wr_en_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wr_data_q, wr_data_d;
    logic [3:0]             byte_en_q, byte_en_d;
`ifdef ARBITER_LOCK_EN
    logic                   lock_q, lock_d;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            last_q    <= IW'(N_MASTERS - 1);
            grant_q   <= '0;
            bus_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            byte_en_q <= '0;
`ifdef ARBITER_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            bus_en_q  <= bus_en_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            byte_en_q <= byte_en_d;
`ifdef ARBITER_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

    logic [N_MASTERS-1:0] req;
    logic                 found;
    logic [IW-1:0]        win;
    int                   idx;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        bus_en_d  = bus_en_q;
        wr_en_d   = wr_en_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        byte_en_d = byte_en_q;
        req       = bus.i_m_bus_en;
        found     = 1'b0;
        win       = '0;
        idx       = 0;
`ifdef ARBITER_LOCK_EN
        lock_d    = lock_q;
        // last_q still names the locked master, so restricting req to it keeps last unchanged.
        if (state_q == IDLE && lock_q) begin
            if (bus.i_m_lock[last_q]) begin
                req          = '0;
                req[last_q]  = bus.i_m_bus_en[last_q];
            end else begin
                lock_d = 1'b0;
            end
        end
`endif
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx = int'(last_q) + i;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = BUSY;
                    last_d       = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    bus_en_d     = 1'b1;
                    wr_en_d      = bus.i_m_wr_en[win];
                    addr_d       = bus.i_m_addr[win];
                    wr_data_d    = bus.i_m_wr_data[win];
                    byte_en_d    = bus.i_m_byte_en[win];
                end
            end
            BUSY: begin
                if (bus.i_ack) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    bus_en_d = 1'b0;
`ifdef ARBITER_LOCK_EN
                    if (bus.i_m_lock[last_q]) lock_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Return path is combinational so the winner sees the ack in the slave's ack cycle.
    always_comb begin
        bus.o_m_ack     = (state_q == BUSY && bus.i_ack) ? grant_q : '0;
        bus.o_m_rd_data = bus.i_rd_data;
        bus.o_grant     = grant_q;
        bus.o_bus_en    = bus_en_q;
        bus.o_wr_en     = wr_en_q;
        bus.o_addr      = addr_q;
        bus.o_wr_data   = wr_data_q;
        bus.o_byte_en   = byte_en_q;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with two masters; define
// ARBITER_LOCK_EN on both bench and RTL to exercise lock mode.
module tb_bus_arbiter;
    localparam int N = 2;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ack_cnt0 = 0;
    int   ack_cnt1 = 0;

    bus_arbiter_if #(.N_MASTERS(N)) bus ();

    bus_arbiter #(.N_MASTERS(N)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    logic [1:0] rr_exp   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
`ifdef ARBITER_LOCK_EN
    logic [1:0] lock_exp [3] = '{2'b10, 2'b10, 2'b01};
`else
    logic [1:0] lock_exp [3] = '{2'b10, 2'b01, 2'b01};
`endif

    initial begin
        bus.i_m_bus_en  = '0;
        bus.i_m_wr_en   = '0;
        bus.i_m_addr    = '0;
        bus.i_m_wr_data = '0;
        bus.i_m_byte_en = '0;
`ifdef ARBITER_LOCK_EN
        bus.i_m_lock    = '0;
`endif
        bus.i_ack       = 1'b0;
        bus.i_rd_data   = '0;

        // Reset and a single read from master 1
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge i_clk);
            chk("rst_bus_en",  64'(bus.o_bus_en), 64'd0);
            chk("rst_grant",   64'(bus.o_grant), 64'd0);
            chk("rst_addr",    64'(bus.o_addr), 64'd0);
            chk("rst_wdata",   64'(bus.o_wr_data), 64'd0);
            chk("rst_be",      64'(bus.o_byte_en), 64'd0);
            chk("rst_wr_en",   64'(bus.o_wr_en), 64'd0);
            chk("rst_m_ack",   64'(bus.o_m_ack), 64'd0);
        end
        step();
        i_rst = 1'b1;
        bus.i_m_bus_en  = 2'b10;
        bus.i_m_addr[1] = 32'h0000_1000;
        @(negedge i_clk);
        chk("rd_idle_bus_en", 64'(bus.o_bus_en), 64'd0);
        step();
        @(negedge i_clk);
        chk("rd_grant",  64'(bus.o_grant), 64'h2);
        chk("rd_addr",   64'(bus.o_addr), 64'h1000);
        chk("rd_wr_en",  64'(bus.o_wr_en), 64'd0);
        chk("rd_bus_en", 64'(bus.o_bus_en), 64'd1);
        chk("rd_noack",  64'(bus.o_m_ack), 64'd0);
        step();
        @(negedge i_clk);
        chk("rd_wait_noack", 64'(bus.o_m_ack), 64'd0);
        step();
        bus.i_ack     = 1'b1;
        bus.i_rd_data = 32'hDEAD_BEEF;
        @(negedge i_clk);
        chk("rd_ack",   64'(bus.o_m_ack), 64'h2);
        chk("rd_data",  64'(bus.o_m_rd_data), 64'hDEAD_BEEF);
        step();
        bus.i_ack       = 1'b0;
        bus.i_m_bus_en  = 2'b00;
        @(negedge i_clk);
        chk("rd_done_bus_en", 64'(bus.o_bus_en), 64'd0);
        chk("rd_done_grant",  64'(bus.o_grant), 64'd0);

        // Both masters requesting continuously, slave acks immediately
        for (int t = 0; t < 4; t++) begin
            step();
            bus.i_m_bus_en = 2'b11;
            bus.i_ack      = 1'b0;
            @(negedge i_clk);
            chk("rr_idle_grant", 64'(bus.o_grant), 64'd0);
            chk("rr_idle_bus_en", 64'(bus.o_bus_en), 64'd0);
            step();
            bus.i_ack = 1'b1;
            @(negedge i_clk);
            chk("rr_grant", 64'(bus.o_grant), 64'(rr_exp[t]));
            chk("rr_ack",   64'(bus.o_m_ack), 64'(rr_exp[t]));
            ack_cnt0 += int'(bus.o_m_ack[0]);
            ack_cnt1 += int'(bus.o_m_ack[1]);
        end
        chk("rr_acks_m0", 64'(ack_cnt0), 64'd2);
        chk("rr_acks_m1", 64'(ack_cnt1), 64'd2);
        step();
        bus.i_ack      = 1'b0;
        bus.i_m_bus_en = 2'b00;

        // Write from master 0; inputs change while BUSY
        step();
        bus.i_m_bus_en     = 2'b01;
        bus.i_m_wr_en      = 2'b01;
        bus.i_m_addr[0]    = 32'h0000_2004;
        bus.i_m_wr_data[0] = 32'hA5A5_0001;
        bus.i_m_byte_en[0] = 4'b0011;
        step();
        bus.i_m_bus_en     = 2'b00;
        bus.i_m_wr_en      = 2'b00;
        bus.i_m_addr[0]    = 32'hFFFF_0000;
        bus.i_m_wr_data[0] = 32'h0;
        bus.i_m_byte_en[0] = 4'b1100;
        @(negedge i_clk);
        chk("wr_grant", 64'(bus.o_grant), 64'h1);
        chk("wr_wr_en", 64'(bus.o_wr_en), 64'd1);
        chk("wr_addr",  64'(bus.o_addr), 64'h2004);
        chk("wr_data",  64'(bus.o_wr_data), 64'hA5A5_0001);
        chk("wr_be",    64'(bus.o_byte_en), 64'h3);
        step();
        bus.i_ack = 1'b1;
        @(negedge i_clk);
        chk("wr_hold_addr", 64'(bus.o_addr), 64'h2004);
        chk("wr_hold_data", 64'(bus.o_wr_data), 64'hA5A5_0001);
        chk("wr_bus_en",    64'(bus.o_bus_en), 64'd1);
        chk("wr_ack",       64'(bus.o_m_ack), 64'h1);
        step();
        bus.i_ack = 1'b0;
        @(negedge i_clk);
        chk("wr_done_bus_en", 64'(bus.o_bus_en), 64'd0);

        // Stray ack in IDLE
        step();
        bus.i_ack = 1'b1;
        @(negedge i_clk);
        chk("stray_ack", 64'(bus.o_m_ack), 64'd0);
        step();
        bus.i_ack = 1'b0;
        @(negedge i_clk);
        chk("stray_bus_en", 64'(bus.o_bus_en), 64'd0);

        // Reset during BUSY: last is 0 here, so master 1 wins first
        bus.i_m_bus_en = 2'b10;
        step();
        bus.i_m_bus_en = 2'b00;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("mrst_busy_grant", 64'(bus.o_grant), 64'h2);
        step();
        i_rst     = 1'b1;
        bus.i_ack = 1'b1;
        @(negedge i_clk);
        chk("mrst_noack",  64'(bus.o_m_ack), 64'd0);
        chk("mrst_grant",  64'(bus.o_grant), 64'd0);
        chk("mrst_bus_en", 64'(bus.o_bus_en), 64'd0);
        step();
        bus.i_ack      = 1'b0;
        bus.i_m_bus_en = 2'b11;
        step();
        bus.i_ack      = 1'b1;
        bus.i_m_bus_en = 2'b00;
        @(negedge i_clk);
        chk("mrst_first_grant", 64'(bus.o_grant), 64'h1);
        chk("mrst_first_ack",   64'(bus.o_m_ack), 64'h1);
        step();
        bus.i_ack = 1'b0;

        // Lock: master 1 locks across two transactions, master 0 keeps requesting
        for (int t = 0; t < 3; t++) begin
            bus.i_m_bus_en = (t < 2) ? 2'b11 : 2'b01;
`ifdef ARBITER_LOCK_EN
            bus.i_m_lock   = (t < 2) ? 2'b10 : 2'b00;
`endif
            step();
            bus.i_ack = 1'b1;
            @(negedge i_clk);
            chk("lock_grant", 64'(bus.o_grant), 64'(lock_exp[t]));
            chk("lock_ack",   64'(bus.o_m_ack), 64'(lock_exp[t]));
            step();
            bus.i_ack = 1'b0;
        end
        bus.i_m_bus_en = 2'b00;
`ifdef ARBITER_LOCK_EN
        bus.i_m_lock   = 2'b00;
`endif
        step();
        @(negedge i_clk);
        chk("final_bus_en", 64'(bus.o_bus_en), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
